// File: rtl/unidade_controle_rodadas.sv
// Round controller for the memory game: plays back the stored sequence,
// then collects and checks the player's moves with a per-move timeout.
module unidade_controle_rodadas #(
  parameter bit MOSTRA_EN  = 1'b1,
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       botoesIgualMemoria,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  input  logic       fimT,
  input  logic       timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraT,
  output logic       contaT,
  output logic       mostra_leds,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       fim_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    INICIO_RODADA = 4'h2,
    MOSTRA        = 4'h3,
    PROX_MOSTRA   = 4'h4,
    FIM_MOSTRA    = 4'h5,
    ESPERA        = 4'h6,
    REGISTRA      = 4'h7,
    COMPARA       = 4'h8,
    PROX_JOGADA   = 4'h9,
    FIM_ACERTO    = 4'hA,
    PROX_RODADA   = 4'hB,
    FIM_TIMEOUT   = 4'hD,
    FIM_ERRO      = 4'hE
  } estado_t;

  typedef struct packed {
    logic ze;
    logic ce;
    logic zl;
    logic cl;
    logic zr;
    logic rr;
    logic zt;
    logic ct;
    logic ml;
    logic ac;
    logic er;
    logic pr;
    logic ft;
  } saida_t;

  estado_t estado;
  estado_t prox;
  saida_t  saida;

  always_comb begin
    prox = estado;
    unique case (estado)
      INICIAL:       if (iniciar) prox = PREPARA;
      PREPARA:       prox = INICIO_RODADA;
      INICIO_RODADA: prox = MOSTRA_EN ? MOSTRA : ESPERA;
      MOSTRA:        if (fimT) prox = PROX_MOSTRA;
      PROX_MOSTRA:
        prox = enderecoIgualLimite ? FIM_MOSTRA : MOSTRA;
      FIM_MOSTRA:    prox = ESPERA;
      ESPERA: begin
        if (jogada)
          prox = REGISTRA;
        else if (timeout && TIMEOUT_EN)
          prox = FIM_TIMEOUT;
      end
      REGISTRA:      prox = COMPARA;
      COMPARA: begin
        if (!botoesIgualMemoria)
          prox = FIM_ERRO;
        else if (!enderecoIgualLimite)
          prox = PROX_JOGADA;
        else if (fimL)
          prox = FIM_ACERTO;
        else
          prox = PROX_RODADA;
      end
      PROX_JOGADA:   prox = ESPERA;
      PROX_RODADA:   prox = INICIO_RODADA;
      FIM_ACERTO,
      FIM_ERRO,
      FIM_TIMEOUT:   if (iniciar) prox = PREPARA;
      default:       prox = INICIAL;
    endcase
  end

  // E is stable throughout MOSTRA, so the E==L seen on the way
  // into PROX_MOSTRA decides that state's contaE.
  function automatic saida_t decodifica(estado_t e, logic ult);
    saida_t s;
    s = '0;
    case (e)
      PREPARA: begin
        s.ze = 1'b1;
        s.zl = 1'b1;
        s.zr = 1'b1;
        s.zt = 1'b1;
      end
      INICIO_RODADA,
      FIM_MOSTRA: begin
        s.ze = 1'b1;
        s.zt = 1'b1;
      end
      MOSTRA: begin
        s.ml = 1'b1;
        s.ct = 1'b1;
      end
      PROX_MOSTRA: begin
        s.ml = 1'b1;
        s.zt = 1'b1;
        s.ce = !ult;
      end
      ESPERA:   s.ct = 1'b1;
      REGISTRA: s.rr = 1'b1;
      PROX_JOGADA: begin
        s.ce = 1'b1;
        s.zt = 1'b1;
      end
      PROX_RODADA: begin
        s.cl = 1'b1;
        s.zr = 1'b1;
      end
      FIM_ACERTO: begin
        s.pr = 1'b1;
        s.ac = 1'b1;
      end
      FIM_ERRO: begin
        s.pr = 1'b1;
        s.er = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pr = 1'b1;
        s.er = 1'b1;
        s.ft = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      saida  <= '0;
    end else begin
      estado <= prox;
      saida  <= decodifica(prox, enderecoIgualLimite);
    end
  end

  assign zeraE       = saida.ze;
  assign contaE      = saida.ce;
  assign zeraL       = saida.zl;
  assign contaL      = saida.cl;
  assign zeraR       = saida.zr;
  assign registraR   = saida.rr;
  assign zeraT       = saida.zt;
  assign contaT      = saida.ct;
  assign mostra_leds = saida.ml;
  assign acertou     = saida.ac;
  assign errou       = saida.er;
  assign pronto      = saida.pr;
  assign fim_timeout = saida.ft;
  assign db_estado   = estado;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for unidade_controle_rodadas: random games are expanded into
// per-cycle state/input scripts and replayed against two configurations.
module tb_unidade_controle_rodadas;

  typedef struct packed {
    logic iniciar;
    logic jogada;
    logic igual;
    logic eil;
    logic fimL;
    logic fimT;
    logic timeout;
  } ent_t;

  typedef struct packed {
    logic [3:0] c;
    ent_t       in;
  } passo_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  ent_t        i1 = '0;
  ent_t        i2 = '0;
  logic [12:0] o1;
  logic [12:0] o2;
  logic [3:0]  db1;
  logic [3:0]  db2;

  passo_t q[$];
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  unidade_controle_rodadas dut (
    .clock(clock), .reset(reset),
    .iniciar(i1.iniciar), .jogada(i1.jogada),
    .botoesIgualMemoria(i1.igual),
    .enderecoIgualLimite(i1.eil),
    .fimL(i1.fimL), .fimT(i1.fimT), .timeout(i1.timeout),
    .zeraE(o1[12]), .contaE(o1[11]), .zeraL(o1[10]),
    .contaL(o1[9]), .zeraR(o1[8]), .registraR(o1[7]),
    .zeraT(o1[6]), .contaT(o1[5]), .mostra_leds(o1[4]),
    .acertou(o1[3]), .errou(o1[2]), .pronto(o1[1]),
    .fim_timeout(o1[0]), .db_estado(db1)
  );

  unidade_controle_rodadas #(
    .MOSTRA_EN(1'b0), .TIMEOUT_EN(1'b0)
  ) dut2 (
    .clock(clock), .reset(reset),
    .iniciar(i2.iniciar), .jogada(i2.jogada),
    .botoesIgualMemoria(i2.igual),
    .enderecoIgualLimite(i2.eil),
    .fimL(i2.fimL), .fimT(i2.fimT), .timeout(i2.timeout),
    .zeraE(o2[12]), .contaE(o2[11]), .zeraL(o2[10]),
    .contaL(o2[9]), .zeraR(o2[8]), .registraR(o2[7]),
    .zeraT(o2[6]), .contaT(o2[5]), .mostra_leds(o2[4]),
    .acertou(o2[3]), .errou(o2[2]), .pronto(o2[1]),
    .fim_timeout(o2[0]), .db_estado(db2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Output set each state must show:
  // {zE,cE,zL,cL,zR,rR,zT,cT,leds,acertou,errou,pronto,fim_timeout}
  function automatic logic [12:0] esperado(logic [3:0] c, logic eil);
    logic ze, ce, zl, cl, zr, rr, zt, ct, ml, ac, er, pr, ft;
    {ze, ce, zl, cl, zr, rr, zt, ct, ml, ac, er, pr, ft} = '0;
    case (c)
      4'h1: {ze, zl, zr, zt} = '1;
      4'h2: {ze, zt} = '1;
      4'h3: {ml, ct} = '1;
      4'h4: begin {ml, zt} = '1; ce = !eil; end
      4'h5: {ze, zt} = '1;
      4'h6: ct = 1'b1;
      4'h7: rr = 1'b1;
      4'h9: {ce, zt} = '1;
      4'hB: {cl, zr} = '1;
      4'hA: {pr, ac} = '1;
      4'hE: {pr, er} = '1;
      4'hD: {pr, er, ft} = '1;
      default: ;
    endcase
    return {ze, ce, zl, cl, zr, rr, zt, ct, ml, ac, er, pr, ft};
  endfunction

  function automatic ent_t rnd();
    logic [6:0] v;
    v = 7'($urandom);
    return ent_t'(v);
  endfunction

  function automatic void add(logic [3:0] c, ent_t in);
    passo_t p;
    p.c = c;
    p.in = in;
    q.push_back(p);
  endfunction

  function automatic ent_t com_iniciar(logic v);
    ent_t e;
    e = rnd();
    e.iniciar = v;
    return e;
  endfunction

  // End state held a few cycles, then released by iniciar.
  task automatic fim(input logic [3:0] c);
    int h;
    h = $urandom_range(1, 3);
    for (int k = 0; k < h; k++) add(c, com_iniciar(1'b0));
    add(c, com_iniciar(1'b1));
  endtask

  // fk: 0 all moves right, 1 wrong move, 2 timeout, at level fl item fi.
  task automatic gen_game(input int lmax, input int pt, input bit mo,
                          input bit ten, input int fk, input int fl,
                          input int fi, output int rounds);
    ent_t in;
    int d;
    rounds = 0;
    add(4'h1, rnd());
    for (int l = 0; l <= lmax; l++) begin
      add(4'h2, rnd());
      if (mo) begin
        for (int e = 0; e <= l; e++) begin
          for (int t = 0; t <= pt; t++) begin
            in = rnd();
            in.fimT = (t == pt);
            in.eil = (e == l);
            add(4'h3, in);
          end
          in = rnd();
          in.eil = (e == l);
          add(4'h4, in);
        end
        add(4'h5, rnd());
      end
      for (int e = 0; e <= l; e++) begin
        d = ten ? $urandom_range(0, 3) : $urandom_range(1, 3);
        for (int k = 0; k < d; k++) begin
          in = rnd();
          in.jogada = 1'b0;
          in.timeout = !ten;
          add(4'h6, in);
        end
        if (fk == 2 && l == fl && e == fi) begin
          in = rnd();
          in.jogada = 1'b0;
          in.timeout = 1'b1;
          add(4'h6, in);
          fim(4'hD);
          return;
        end
        in = rnd();
        in.jogada = 1'b1;
        add(4'h6, in);
        add(4'h7, rnd());
        in = rnd();
        in.igual = !(fk == 1 && l == fl && e == fi);
        in.eil = (e == l);
        in.fimL = (l == lmax);
        add(4'h8, in);
        if (!in.igual) begin
          fim(4'hE);
          return;
        end
        if (e < l) add(4'h9, rnd());
      end
      if (l == lmax) begin
        fim(4'hA);
        return;
      end
      add(4'hB, rnd());
      rounds++;
    end
  endtask

  task automatic run(input bit sel, output int nl);
    passo_t p;
    nl = 0;
    while (q.size() > 0) begin
      p = q.pop_front();
      @(negedge clock);
      if (!sel) begin
        chk("estado1", 32'(db1), 32'(p.c));
        chk("saidas1", 32'(o1), 32'(esperado(p.c, p.in.eil)));
        if (o1[9]) nl++;
        i1 = p.in;
      end else begin
        chk("estado2", 32'(db2), 32'(p.c));
        chk("saidas2", 32'(o2), 32'(esperado(p.c, p.in.eil)));
        if (o2[9]) nl++;
        i2 = p.in;
      end
    end
  endtask

  task automatic jogo(input bit sel, input int lmax, input int pt,
                      input int fk, input int fl, input int fi);
    int r;
    int nl;
    gen_game(lmax, pt, !sel, !sel, fk, fl, fi, r);
    run(sel, nl);
    chk(sel ? "niveis2" : "niveis1", 32'(nl), 32'(r));
  endtask

  initial begin
    ent_t z;
    int lm;
    int fk;
    int fl;
    z = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_estado1", 32'(db1), 0);
    chk("rst_saidas1", 32'(o1), 0);
    chk("rst_estado2", 32'(db2), 0);
    chk("rst_saidas2", 32'(o2), 0);
    @(negedge clock);
    reset = 1'b1;

    add(4'h0, com_iniciar(1'b0));
    add(4'h0, com_iniciar(1'b0));
    add(4'h0, com_iniciar(1'b1));
    jogo(0, 0, 2, 0, 0, 0);
    jogo(0, 1, $urandom_range(0, 3), 0, 0, 0);
    jogo(0, 2, 1, 1, 0, 0);
    jogo(0, 2, 1, 2, 1, 1);
    for (int n = 0; n < 6; n++) begin
      lm = $urandom_range(0, 3);
      fk = $urandom_range(0, 2);
      fl = $urandom_range(0, lm);
      jogo(0, lm, $urandom_range(0, 3), fk, fl, $urandom_range(0, fl));
    end
    i1 = '0;

    add(4'h0, com_iniciar(1'b0));
    add(4'h0, com_iniciar(1'b1));
    for (int n = 0; n < 5; n++) begin
      lm = $urandom_range(0, 3);
      fk = $urandom_range(0, 1);
      fl = $urandom_range(0, lm);
      jogo(1, lm, 0, fk, fl, $urandom_range(0, fl));
    end
    i2 = '0;

    @(negedge clock);
    reset = 1'b0;
    i1 = '0;
    #1;
    chk("rst2_estado1", 32'(db1), 0);
    chk("rst2_estado2", 32'(db2), 0);
    @(negedge clock);
    reset = 1'b1;
    add(4'h0, z);
    add(4'h0, '{iniciar: 1'b1, default: 1'b0});
    add(4'h1, z);
    add(4'h2, z);
    add(4'h3, '{eil: 1'b1, default: 1'b0});
    add(4'h3, '{eil: 1'b1, fimT: 1'b1, default: 1'b0});
    add(4'h4, '{eil: 1'b1, default: 1'b0});
    add(4'h5, z);
    add(4'h6, z);
    add(4'h6, z);
    begin
      int nl;
      run(0, nl);
    end
    @(negedge clock);
    chk("espera_pre_rst", 32'(db1), 32'h6);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_estado", 32'(db1), 0);
    chk("t1_saidas", 32'(o1), 0);
    i1.iniciar = 1'b1;
    @(negedge clock);
    chk("t1_ignora_ini", 32'(db1), 0);
    @(posedge clock);
    #1;
    chk("t1_ignora_ini2", 32'(db1), 0);
    chk("t1_saidas2", 32'(o1), 0);
    i1 = '0;
    @(negedge clock);
    reset = 1'b1;
    add(4'h0, com_iniciar(1'b0));
    add(4'h0, com_iniciar(1'b1));
    jogo(0, 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
